// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-enable 7-segment display with one shared hex decoder.
// Each digit slot is a blanking gap followed by a show window. The display
// value is double-buffered and committed only at frame boundaries.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scan disabled, all digits off, idx held at 0
// BLANK | all digits off, hex_out/dp_out already present digit idx
// SHOW  | digit_en[idx] on for SCAN_DIV-BLANK_CYCLES cycles

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    dp_out,
    output logic                    update_ack,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0] shadow_val, shadow_val_nxt, active_val, active_val_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt, active_dp, active_dp_nxt;
    logic                    pending, pending_nxt;
    logic                    enter_blank, commit, hide;
    logic [3:0]              hex_nxt;
    logic                    dp_nxt, ack_nxt, fd_nxt;
    logic [NUM_DIGITS-1:0]   en_nxt;

    // Slot sequencing: down-counter reloaded on every state entry, advances at zero.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = BLANK_LOAD;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_nxt = SHOW;
                        cnt_nxt   = SHOW_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == '0) begin
                        state_nxt = BLANK;
                        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Hide digit idx when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        hide = (idx_nxt != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((IDX_W'(k) >= idx_nxt) && (active_val[4*k +: 4] != 4'h0)) hide = 1'b0;
        end
    end
`else
    assign hide = 1'b0;
`endif

    // Buffer management and next values for the registered outputs.
    always_comb begin
        enter_blank    = (state_nxt == BLANK) && (state != BLANK);
        commit         = enter_blank && (idx_nxt == '0);
        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
        active_val_nxt = active_val;
        active_dp_nxt  = active_dp;
        pending_nxt    = pending;
        ack_nxt        = 1'b0;
        if (commit && (load || pending)) begin
            // A load coinciding with the frame boundary goes straight to the active buffer.
            active_val_nxt = load ? value : shadow_val;
            active_dp_nxt  = load ? dp_in : shadow_dp;
            pending_nxt    = 1'b0;
            ack_nxt        = 1'b1;
        end else if (load) begin
            shadow_val_nxt = value;
            shadow_dp_nxt  = dp_in;
            pending_nxt    = 1'b1;
        end

        hex_nxt = hex_out;
        dp_nxt  = dp_out;
        if (enter_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == IDX_W'(k)) begin
                    hex_nxt = active_val_nxt[4*k +: 4];
                    dp_nxt  = active_dp_nxt[k];
                end
            end
        end

        en_nxt = '0;
        if ((state_nxt == SHOW) && !hide) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == IDX_W'(k)) en_nxt[k] = 1'b1;
            end
        end
        fd_nxt = (state_nxt == SHOW) && (idx_nxt == LAST_IDX) && (cnt_nxt == '0);
    end

    // FSM state, digit index and slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shadow/active display buffers and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            active_val <= active_val_nxt;
            active_dp  <= active_dp_nxt;
            pending    <= pending_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out    <= '0;
            dp_out     <= 1'b0;
            digit_en   <= '0;
            update_ack <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            hex_out    <= hex_nxt;
            dp_out     <= dp_nxt;
            digit_en   <= en_nxt;
            update_ack <= ack_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed testbench for seven_seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2).
// A frame is 32 cycles; frame cycle c covers digit c/8, with slot cycles 0,1 blank.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  hex_out;
    logic [3:0]  digit_en;
    logic        dp_out;
    logic        update_ack;
    logic        frame_done;

    int n_chk = 0;
    int n_pass = 0;

    logic [3:0] cap_en [32];
    logic [3:0] cap_hex[32];
    logic       cap_dp [32];
    logic       cap_ack[32];
    logic       cap_fd [32];

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .hex_out    (hex_out),
        .digit_en   (digit_en),
        .dp_out     (dp_out),
        .update_ack (update_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records one full frame starting at frame cycle 0.
    task automatic capture_frame();
        for (int c = 0; c < 32; c++) begin
            cap_en[c]  = digit_en;
            cap_hex[c] = hex_out;
            cap_dp[c]  = dp_out;
            cap_ack[c] = update_ack;
            cap_fd[c]  = frame_done;
            step();
        end
    endtask

    // Advances to the last cycle of the current frame (frame_done high).
    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_chk++;
        if (frame_done !== 1'b1) $display("FAIL wait_frame_done: frame_done=%b required 1", frame_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({digit_en, hex_out, dp_out, update_ack, frame_done} !== 11'd0)
            $display("FAIL reset_initial: outputs=%h required 0", {digit_en, hex_out, dp_out, update_ack, frame_done});
        else n_pass++;
        step();
        rst_n = 1'b1;
        value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_chk++;
        if (digit_en !== 4'b0001 || hex_out !== 4'h4)
            $display("FAIL reset_precond: digit_en=%b hex=%h required 0001/4", digit_en, hex_out);
        else n_pass++;
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({digit_en, hex_out, dp_out, update_ack, frame_done} !== 11'd0)
            $display("FAIL reset_async: outputs=%h required 0", {digit_en, hex_out, dp_out, update_ack, frame_done});
        else n_pass++;
        enable = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame();
        logic [15:0] v;
        logic [3:0]  dpm, e_en;
        int d, p;
        v = 16'h1234; dpm = 4'b0100;
        value = v; dp_in = dpm; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        capture_frame();
        for (int c = 0; c < 32; c++) begin
            d = c / 8; p = c % 8;
            e_en = (p < 2) ? 4'b0000 : 4'(1 << d);
            n_chk++;
            if (cap_en[c] !== e_en) $display("FAIL frame_en c=%0d got %b required %b", c, cap_en[c], e_en);
            else n_pass++;
            n_chk++;
            if (cap_hex[c] !== v[4*d +: 4] || cap_dp[c] !== dpm[d])
                $display("FAIL frame_hex c=%0d got %h/%b required %h/%b", c, cap_hex[c], cap_dp[c], v[4*d +: 4], dpm[d]);
            else n_pass++;
            n_chk++;
            if (cap_ack[c] !== (c == 0) || cap_fd[c] !== (c == 31))
                $display("FAIL frame_pulses c=%0d ack=%b fd=%b required %b/%b", c, cap_ack[c], cap_fd[c], c == 0, c == 31);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_load();
        logic [15:0] v_old, v_new;
        logic [3:0]  e_en;
        int d, p;
        v_old = 16'h1234; v_new = 16'hABCD;
        for (int c = 0; c < 32; c++) begin
            d = c / 8; p = c % 8;
            e_en = (p < 2) ? 4'b0000 : 4'(1 << d);
            n_chk++;
            if (digit_en !== e_en || hex_out !== v_old[4*d +: 4] || update_ack !== 1'b0)
                $display("FAIL midload_old c=%0d en=%b hex=%h ack=%b required %b/%h/0", c, digit_en, hex_out, update_ack, e_en, v_old[4*d +: 4]);
            else n_pass++;
            if (c == 11) begin value = v_new; dp_in = 4'b0000; load = 1'b1; end
            if (c == 12) load = 1'b0;
            step();
        end
        capture_frame();
        for (int c = 0; c < 32; c++) begin
            d = c / 8; p = c % 8;
            e_en = (p < 2) ? 4'b0000 : 4'(1 << d);
            n_chk++;
            if (cap_en[c] !== e_en || cap_hex[c] !== v_new[4*d +: 4] || cap_dp[c] !== 1'b0)
                $display("FAIL midload_new c=%0d en=%b hex=%h dp=%b required %b/%h/0", c, cap_en[c], cap_hex[c], cap_dp[c], e_en, v_new[4*d +: 4]);
            else n_pass++;
            n_chk++;
            if (cap_ack[c] !== (c == 0)) $display("FAIL midload_ack c=%0d got %b required %b", c, cap_ack[c], c == 0);
            else n_pass++;
        end
    endtask

    task automatic test_last_load_wins();
        logic [15:0] v_cur;
        int d, acks;
        v_cur = 16'hABCD;
        acks = 0;
        for (int c = 0; c < 32; c++) begin
            d = c / 8;
            n_chk++;
            if (hex_out !== v_cur[4*d +: 4]) $display("FAIL lastwin_hold c=%0d hex=%h required %h", c, hex_out, v_cur[4*d +: 4]);
            else n_pass++;
            if (update_ack === 1'b1) acks++;
            if (c == 3)  begin value = 16'h1111; load = 1'b1; end
            if (c == 4)  load = 1'b0;
            if (c == 20) begin value = 16'h2222; load = 1'b1; end
            if (c == 21) load = 1'b0;
            step();
        end
        capture_frame();
        for (int c = 0; c < 32; c++) begin
            n_chk++;
            if (cap_hex[c] !== 4'h2) $display("FAIL lastwin_hex c=%0d got %h required 2", c, cap_hex[c]);
            else n_pass++;
            if (cap_ack[c] === 1'b1) acks++;
        end
        n_chk++;
        if (acks != 1 || cap_ack[0] !== 1'b1) $display("FAIL lastwin_acks got %0d (first=%b) required 1 at frame start", acks, cap_ack[0]);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [15:0] v;
        logic [3:0]  e_en;
        int d, p;
        v = 16'h5678;
        wait_fd();
        value = v; dp_in = 4'b1000; load = 1'b1;
        step();
        load = 1'b0;
        capture_frame();
        for (int c = 0; c < 32; c++) begin
            d = c / 8; p = c % 8;
            e_en = (p < 2) ? 4'b0000 : 4'(1 << d);
            n_chk++;
            if (cap_en[c] !== e_en || cap_hex[c] !== v[4*d +: 4] || cap_dp[c] !== (d == 3))
                $display("FAIL bypass_frame c=%0d en=%b hex=%h dp=%b required %b/%h/%b", c, cap_en[c], cap_hex[c], cap_dp[c], e_en, v[4*d +: 4], d == 3);
            else n_pass++;
            n_chk++;
            if (cap_ack[c] !== (c == 0)) $display("FAIL bypass_ack c=%0d got %b required %b", c, cap_ack[c], c == 0);
            else n_pass++;
        end
        capture_frame();
        for (int c = 0; c < 32; c++) begin
            d = c / 8;
            n_chk++;
            if (cap_ack[c] !== 1'b0 || cap_hex[c] !== v[4*d +: 4])
                $display("FAIL bypass_no_pending c=%0d ack=%b hex=%h required 0/%h", c, cap_ack[c], cap_hex[c], v[4*d +: 4]);
            else n_pass++;
        end
    endtask

    task automatic test_disable();
        for (int i = 0; i < 18; i++) step();
        n_chk++;
        if (digit_en !== 4'b0100) $display("FAIL disable_precond en=%b required 0100", digit_en);
        else n_pass++;
        enable = 1'b0;
        step();
        n_chk++;
        if (digit_en !== 4'b0000 || hex_out !== 4'h6) $display("FAIL disable_off en=%b hex=%h required 0000/6", digit_en, hex_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (digit_en !== 4'b0000 || frame_done !== 1'b0) $display("FAIL disable_idle en=%b fd=%b required 0000/0", digit_en, frame_done);
            else n_pass++;
        end
        enable = 1'b1;
        step();
        n_chk++;
        if (digit_en !== 4'b0000 || hex_out !== 4'h8 || update_ack !== 1'b0)
            $display("FAIL reenable_blank en=%b hex=%h ack=%b required 0000/8/0", digit_en, hex_out, update_ack);
        else n_pass++;
        step();
        n_chk++;
        if (digit_en !== 4'b0000) $display("FAIL reenable_blank2 en=%b required 0000", digit_en);
        else n_pass++;
        step();
        n_chk++;
        if (digit_en !== 4'b0001 || hex_out !== 4'h8) $display("FAIL reenable_show en=%b hex=%h required 0001/8", digit_en, hex_out);
        else n_pass++;
    endtask

    task automatic test_leading_zero();
        logic [15:0] v;
        logic [3:0]  e_en;
        logic        shown;
        int d, p;
        for (int pass = 0; pass < 2; pass++) begin
            v = (pass == 0) ? 16'h0050 : 16'h0000;
            value = v; dp_in = 4'b0000; load = 1'b1;
            step();
            load = 1'b0;
            wait_fd();
            step();
            capture_frame();
            for (int c = 0; c < 32; c++) begin
                d = c / 8; p = c % 8;
`ifdef LEADING_ZERO_BLANK_EN
                shown = (pass == 0) ? (d <= 1) : (d == 0);
`else
                shown = 1'b1;
`endif
                e_en = (p < 2 || !shown) ? 4'b0000 : 4'(1 << d);
                n_chk++;
                if (cap_en[c] !== e_en || cap_hex[c] !== v[4*d +: 4])
                    $display("FAIL lzb_v%0d c=%0d en=%b hex=%h required %b/%h", pass, c, cap_en[c], cap_hex[c], e_en, v[4*d +: 4]);
                else n_pass++;
                n_chk++;
                if (cap_fd[c] !== (c == 31) || cap_ack[c] !== (c == 0))
                    $display("FAIL lzb_pulses_v%0d c=%0d fd=%b ack=%b required %b/%b", pass, c, cap_fd[c], cap_ack[c], c == 31, c == 0);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe_load();
        test_last_load_wins();
        test_bypass();
        test_disable();
        test_leading_zero();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
